bcd_entry_n: RTL and testbench
==============================

BCD_ENTRY_N -- requirements
Module: bcd_entry_n

Interface
REQ-001 Parameter DIGITS, default 3, number of BCD digits per entry; legal range 2..8.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchroniser flops on key_in and sign_in; legal range 2..3.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low: state is reset on a clk rising edge while rst=0.
REQ-005 key_in  input  1  asynchronous digit-key level; each rising edge is one press.
REQ-006 key_num  input  4  BCD digit presented with the key press; sampled on the detected press cycle.
REQ-007 sign_in  input  1  asynchronous sign switch level: 1 = negative, 0 = positive.
REQ-008 clr_in  input  1  synchronous one-cycle pulse that abandons the entry in progress.
REQ-009 curr_digits  output  4*DIGITS  digits being entered; nibble k = 10^k place.
REQ-010 temp_digits  output  4*DIGITS  last committed digits; same nibble order.
REQ-011 press_cnt  output  4  number of accepted presses in the current entry, 0..DIGITS.
REQ-012 track_inp  output  DIGITS+1  one-hot press-position indicator; bit press_cnt set.
REQ-013 curr_sign_mode  output  1  synchronised sign_in.
REQ-014 temp_sign_mode  output  1  sign captured at commit.
REQ-015 sign  output  4  display code: NEGATIVE when curr_sign_mode=1, else OFF (constants.vh).
REQ-016 commit  output  1  one-cycle pulse in the cycle after temp_* update.
REQ-017 err  output  1  one-cycle pulse on a rejected press.

Function
REQ-018 key_in and sign_in SHALL each pass through SYNC_STAGES flops; a press SHALL be detected as a 0->1 transition of the synchronised key, one cycle wide, independent of how long key_in is held.
REQ-019 Press latency: a detected press SHALL update outputs in the first cycle after detection; key_num SHALL be sampled in the detection cycle.
REQ-020 FSM states: ENTRY (press_cnt < DIGITS) and CONFIRM (press_cnt = DIGITS).
REQ-021 ENTRY, valid press (key_num <= 9): nibble press_cnt of curr_digits <= key_num; press_cnt increments; track_inp shifts left by 1.
REQ-022 ENTRY, invalid press (key_num >= 10): digits, press_cnt and track_inp SHALL be unchanged; err pulses once.
REQ-023 CONFIRM, any press (key_num ignored, no err): temp_digits <= curr_digits; temp_sign_mode <= curr_sign_mode; press_cnt <= 0; track_inp <= 1; commit pulses the next cycle.
REQ-024 curr_digits SHALL hold its values after commit until overwritten by new presses; unentered nibbles keep their prior values.
REQ-025 clr_in=1: press_cnt <= 0, track_inp <= 1, curr_digits <= 0; temp_* unchanged; any press detected in the same cycle SHALL be discarded, with no err.
REQ-026 curr_sign_mode SHALL follow synchronised sign_in every cycle; sign is combinational from curr_sign_mode.
REQ-027 A sign change in the commit cycle SHALL NOT affect that commit; temp_sign_mode takes the curr_sign_mode registered before that edge.
REQ-028 press_cnt SHALL never exceed DIGITS; track_inp SHALL always be exactly one-hot.

Reset
REQ-029 With rst=0 at a clk edge: curr_digits=0, temp_digits=0, press_cnt=0, track_inp=1, curr_sign_mode=0, temp_sign_mode=0, sign=OFF, commit=0, err=0, synchroniser flops=0.
REQ-030 Reset mid-entry SHALL discard the partial entry and previous commit; the first post-reset press lands in nibble 0.
REQ-031 key_in held high through reset release SHALL NOT count as a press until it falls and rises again.

Verification (DIGITS=3)
REQ-032 Presses 5,2,7 then any key -> curr_digits=0x725, temp_digits=0x725, commit pulses once, press_cnt=0, track_inp=0001.
REQ-033 Press 4, then press 12 -> err pulses once, press_cnt=1, nibble 1 unchanged; then press 3 -> curr_digits[7:0]=0x34.
REQ-034 key_in held high for 50 cycles -> exactly one press accepted.
REQ-035 sign_in=1, presses 1,2,3, sign_in=0 toggled in the confirm-press detection cycle -> temp_sign_mode=1, sign=OFF afterwards.
REQ-036 Presses 9,9, then clr_in coincident with a press -> press_cnt=0, curr_digits=0, temp_digits unchanged, no err.
REQ-037 Presses 1,2, then rst=0 for 1 cycle with key_in high -> all REQ-029 values; no press counted until key_in falls and rises again.

Source files
------------

// File: rtl/bcd_entry_n.sv
// Multi-digit BCD keypad entry: synchronises an asynchronous key and sign switch,
// collects DIGITS presses into curr_digits, and commits them on a further press.
module bcd_entry_n #(
    parameter int DIGITS      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_in,
    input  logic [3:0]            key_num,
    input  logic                  sign_in,
    input  logic                  clr_in,
    output logic [4*DIGITS-1:0]   curr_digits,
    output logic [4*DIGITS-1:0]   temp_digits,
    output logic [3:0]            press_cnt,
    output logic [DIGITS:0]       track_inp,
    output logic                  curr_sign_mode,
    output logic                  temp_sign_mode,
    output logic [3:0]            sign,
    output logic                  commit,
    output logic                  err,
    output logic                  fsm_state
);

    localparam logic [3:0] SIGN_OFF      = 4'hF;
    localparam logic [3:0] SIGN_NEGATIVE = 4'hA;
    localparam logic       ENTRY         = 1'b0;
    localparam logic       CONFIRM       = 1'b1;
    localparam logic [3:0] LAST_CNT      = 4'(DIGITS - 1);

    // Handshake: key_in is a level, a press is a one-cycle pulse on the synchronised
    // rising edge; commit and err are one-cycle pulses with no back-pressure.

    logic [SYNC_STAGES-1:0] key_sync;
    logic [SYNC_STAGES-1:0] sign_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   key_prev;
    logic                   press;
    logic                   commit_pend;
    logic                   state_q;

    // key_prev is forced high until the synchroniser holds a real sample, so a key
    // held through reset release is not mistaken for a press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            key_sync  <= '0;
            sign_sync <= '0;
            fill      <= '0;
            key_prev  <= 1'b1;
        end else begin
            key_sync  <= {key_sync[SYNC_STAGES-2:0], key_in};
            sign_sync <= {sign_sync[SYNC_STAGES-2:0], sign_in};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            key_prev  <= fill[SYNC_STAGES-1] ? key_sync[SYNC_STAGES-1] : 1'b1;
        end
    end

    assign press          = key_sync[SYNC_STAGES-1] & ~key_prev;
    assign curr_sign_mode = sign_sync[SYNC_STAGES-1];
    assign sign           = curr_sign_mode ? SIGN_NEGATIVE : SIGN_OFF;
    assign fsm_state      = state_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            curr_digits    <= '0;
            temp_digits    <= '0;
            press_cnt      <= '0;
            track_inp      <= (DIGITS+1)'(1);
            temp_sign_mode <= 1'b0;
            commit_pend    <= 1'b0;
            commit         <= 1'b0;
            err            <= 1'b0;
            state_q        <= ENTRY;
        end else begin
            err         <= 1'b0;
            commit_pend <= 1'b0;
            commit      <= commit_pend;
            if (clr_in) begin
                press_cnt   <= '0;
                track_inp   <= (DIGITS+1)'(1);
                curr_digits <= '0;
                state_q     <= ENTRY;
            end else if (press) begin
                if (state_q == CONFIRM) begin
                    temp_digits    <= curr_digits;
                    temp_sign_mode <= curr_sign_mode;
                    press_cnt      <= '0;
                    track_inp      <= (DIGITS+1)'(1);
                    commit_pend    <= 1'b1;
                    state_q        <= ENTRY;
                end else if (key_num <= 4'd9) begin
                    for (int k = 0; k < DIGITS; k++) begin
                        if (press_cnt == 4'(k)) curr_digits[4*k +: 4] <= key_num;
                    end
                    press_cnt <= press_cnt + 4'd1;
                    track_inp <= track_inp << 1;
                    if (press_cnt == LAST_CNT) state_q <= CONFIRM;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_entry_n.sv
// Directed bench for bcd_entry_n (DIGITS=3): driver tasks issue presses, expected
// commit/err events go into queues, and a monitor pops them when the DUT pulses.
module tb_bcd_entry_n;

  localparam logic [3:0] SIGN_OFF = 4'hF;
  localparam logic [3:0] SIGN_NEG = 4'hA;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_in = 1'b0;
  logic [3:0]  key_num = 4'd0;
  logic        sign_in = 1'b0;
  logic        clr_in = 1'b0;
  logic [11:0] curr_digits;
  logic [11:0] temp_digits;
  logic [3:0]  press_cnt;
  logic [3:0]  track_inp;
  logic        curr_sign_mode;
  logic        temp_sign_mode;
  logic [3:0]  sign;
  logic        commit;
  logic        err;
  logic        fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  // commit entries: {temp_sign_mode, temp_digits}; err entries: {curr_digits, press_cnt}
  logic [12:0] commit_q[$];
  logic [15:0] err_q[$];

  bcd_entry_n #(.DIGITS(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_num(key_num), .sign_in(sign_in),
    .clr_in(clr_in), .curr_digits(curr_digits), .temp_digits(temp_digits),
    .press_cnt(press_cnt), .track_inp(track_inp), .curr_sign_mode(curr_sign_mode),
    .temp_sign_mode(temp_sign_mode), .sign(sign), .commit(commit), .err(err),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (commit) begin
      if (commit_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_commit: got commit=1 expected none");
      end else begin
        logic [12:0] e;
        e = commit_q.pop_front();
        chk("commit_temp", {temp_sign_mode, temp_digits}, 32'(e));
      end
    end
    if (err) begin
      if (err_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_err: got err=1 expected none");
      end else begin
        logic [15:0] e;
        e = err_q.pop_front();
        chk("err_state", {curr_digits, press_cnt}, 32'(e));
      end
    end
  end

  // drivers
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_hold(input logic [3:0] num, input int hold);
    @(posedge clk); #1;
    key_num = num;
    key_in  = 1'b1;
    cycles(hold);
    key_in = 1'b0;
    cycles(5);
  endtask

  task automatic press(input logic [3:0] num);
    press_hold(num, 4);
  endtask

  task automatic check_state(input string tag, input logic [11:0] cd, input logic [3:0] pc,
                             input logic [3:0] tr);
    @(negedge clk);
    chk({tag, "_curr"}, 32'(curr_digits), 32'(cd));
    chk({tag, "_cnt"}, 32'(press_cnt), 32'(pc));
    chk({tag, "_track"}, 32'(track_inp), 32'(tr));
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    chk({tag, "_curr"}, 32'(curr_digits), 32'h0);
    chk({tag, "_temp"}, 32'(temp_digits), 32'h0);
    chk({tag, "_cnt"}, 32'(press_cnt), 32'h0);
    chk({tag, "_track"}, 32'(track_inp), 32'h1);
    chk({tag, "_csm"}, 32'(curr_sign_mode), 32'h0);
    chk({tag, "_tsm"}, 32'(temp_sign_mode), 32'h0);
    chk({tag, "_sign"}, 32'(sign), 32'(SIGN_OFF));
    chk({tag, "_commit"}, 32'(commit), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  initial begin
    cycles(3);
    check_reset_values("reset");
    @(posedge clk); #1 rst = 1'b1;
    cycles(3);

    // 5,2,7 then confirm
    press(4'd5);
    press(4'd2);
    press(4'd7);
    check_state("entry3", 12'h725, 4'd3, 4'b1000);
    commit_q.push_back({1'b0, 12'h725});
    press(4'd0);
    check_state("confirm", 12'h725, 4'd0, 4'b0001);
    chk("confirm_temp", 32'(temp_digits), 32'h725);

    // invalid key rejected, earlier nibble kept
    press(4'd4);
    err_q.push_back({12'h724, 4'd1});
    press(4'd12);
    check_state("after_err", 12'h724, 4'd1, 4'b0010);
    press(4'd3);
    check_state("after_3", 12'h734, 4'd2, 4'b0100);

    // long hold counts once
    press_hold(4'd8, 50);
    check_state("long_hold", 12'h834, 4'd3, 4'b1000);

    // clear abandons entry
    @(posedge clk); #1 clr_in = 1'b1;
    @(posedge clk); #1 clr_in = 1'b0;
    check_state("clr", 12'h000, 4'd0, 4'b0001);
    chk("clr_temp", 32'(temp_digits), 32'h725);

    // negative sign captured even though switch drops during confirm detection
    sign_in = 1'b1;
    cycles(4);
    @(negedge clk);
    chk("sign_neg", 32'(sign), 32'(SIGN_NEG));
    press(4'd1);
    press(4'd2);
    press(4'd3);
    check_state("signed_entry", 12'h321, 4'd3, 4'b1000);
    commit_q.push_back({1'b1, 12'h321});
    @(posedge clk); #1;
    key_num = 4'd6;
    key_in  = 1'b1;
    cycles(2);
    sign_in = 1'b0;
    cycles(3);
    key_in = 1'b0;
    cycles(5);
    @(negedge clk);
    chk("tsm_after", 32'(temp_sign_mode), 32'h1);
    chk("temp_signed", 32'(temp_digits), 32'h321);
    chk("sign_off", 32'(sign), 32'(SIGN_OFF));

    // clr coincident with a detected press
    press(4'd9);
    press(4'd9);
    check_state("nine_nine", 12'h399, 4'd2, 4'b0100);
    @(posedge clk); #1;
    key_num = 4'd5;
    key_in  = 1'b1;
    cycles(2);
    clr_in = 1'b1;
    cycles(1);
    clr_in = 1'b0;
    cycles(2);
    key_in = 1'b0;
    cycles(5);
    check_state("clr_press", 12'h000, 4'd0, 4'b0001);
    chk("clr_press_temp", 32'(temp_digits), 32'h321);

    // reset with key held high
    press(4'd1);
    press(4'd2);
    check_state("pre_reset", 12'h021, 4'd2, 4'b0100);
    @(posedge clk); #1;
    key_num = 4'd7;
    key_in  = 1'b1;
    rst     = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    check_reset_values("mid_reset");
    cycles(10);
    check_state("held_key", 12'h000, 4'd0, 4'b0001);
    key_in = 1'b0;
    cycles(5);
    press(4'd6);
    check_state("post_reset", 12'h006, 4'd1, 4'b0010);

    cycles(5);
    chk("commit_q_drained", 32'(commit_q.size()), 32'h0);
    chk("err_q_drained", 32'(err_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
